// File: rtl/rf_write_port_ctrl.sv
// Register-file write-port controller.
// Merges single-cycle ALU writes and buffered load returns into one registered
// write per cycle. Writes to R15 are diverted to the PC path. A pending-write
// mask of live queued loads is exported for decode interlocks.
// Optional statistics counters are enabled by defining RF_WRITE_PORT_CTRL_STATS_EN.
module rf_write_port_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_we,
  input  logic [3:0]             alu_wa,
  input  logic [DW-1:0]          alu_wd,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [3:0]             ld_wa,
  input  logic [DW-1:0]          ld_wd,
  output logic                   we3,
  output logic [3:0]             wa3,
  output logic [DW-1:0]          wd3,
  output logic                   pc_we,
  output logic [DW-1:0]          pc_wd,
  output logic [14:0]            pend_mask,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef RF_WRITE_PORT_CTRL_STATS_EN
  ,
  output logic [15:0]            kill_cnt,
  output logic [15:0]            stall_cyc
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // FIFO storage and bookkeeping
  logic [3:0]       ent_wa_q [DEPTH];
  logic [3:0]       ent_wa_d [DEPTH];
  logic [DW-1:0]    ent_wd_q [DEPTH];
  logic [DW-1:0]    ent_wd_d [DEPTH];
  logic [DEPTH-1:0] ent_vld_q, ent_vld_d;
  logic [DEPTH-1:0] ent_kill_q, ent_kill_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [14:0]      pend_q, pend_d;

  // Registered write-port outputs
  logic             we3_q, we3_d;
  logic [3:0]       wa3_q, wa3_d;
  logic [DW-1:0]    wd3_q, wd3_d;
  logic             pc_we_q, pc_we_d;
  logic [DW-1:0]    pc_wd_q, pc_wd_d;

  // Per-cycle decisions
  logic             ld_acc;
  logic             pop;
  logic             enq;
  logic             iss_en;
  logic [3:0]       iss_wa;
  logic [DW-1:0]    iss_wd;
  logic [DEPTH-1:0] kill_hit;
  logic             enq_kill;

  // Ready depends on the pre-pop count only, so a full FIFO never reuses a slot in the pop cycle.
  assign ld_ready   = (cnt_q < CW'(DEPTH));
  assign ld_acc     = ld_valid & ld_ready;
  assign fifo_count = cnt_q;
  assign pend_mask  = pend_q;
  assign we3        = we3_q;
  assign wa3        = wa3_q;
  assign wd3        = wd3_q;
  assign pc_we      = pc_we_q;
  assign pc_wd      = pc_wd_q;

  // Source selection: ALU first, then FIFO head, then bypass of an accepted load.
  always_comb begin
    pop    = 1'b0;
    enq    = 1'b0;
    iss_en = 1'b0;
    iss_wa = alu_wa;
    iss_wd = alu_wd;
    if (alu_we) begin
      iss_en = 1'b1;
      enq    = ld_acc;
    end else if (cnt_q != '0) begin
      pop    = 1'b1;
      iss_en = ~ent_kill_q[rd_ptr_q];
      iss_wa = ent_wa_q[rd_ptr_q];
      iss_wd = ent_wd_q[rd_ptr_q];
      enq    = ld_acc;
    end else if (ld_acc) begin
      iss_en = 1'b1;
      iss_wa = ld_wa;
      iss_wd = ld_wd;
    end
  end

  // WAW kill: a younger ALU write supersedes every queued or same-cycle load to the same register.
  always_comb begin
    kill_hit = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      kill_hit[i] = alu_we & ent_vld_q[i] & ~ent_kill_q[i] & (ent_wa_q[i] == alu_wa);
    end
    enq_kill = alu_we & (ld_wa == alu_wa);
  end

  // FIFO next state: kill marking, pop of the head, push at the tail.
  always_comb begin
    ent_wa_d   = ent_wa_q;
    ent_wd_d   = ent_wd_q;
    ent_vld_d  = ent_vld_q;
    ent_kill_d = ent_kill_q | kill_hit;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (pop) begin
      ent_vld_d[rd_ptr_q]  = 1'b0;
      ent_kill_d[rd_ptr_q] = 1'b0;
      rd_ptr_d             = rd_ptr_q + AW'(1);
    end
    if (enq) begin
      ent_wa_d[wr_ptr_q]   = ld_wa;
      ent_wd_d[wr_ptr_q]   = ld_wd;
      ent_vld_d[wr_ptr_q]  = 1'b1;
      ent_kill_d[wr_ptr_q] = enq_kill;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end
    cnt_d = cnt_q + CW'(enq) - CW'(pop);
  end

  // Pending mask from the next FIFO state so it is valid the cycle after any change.
  always_comb begin
    pend_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned r = 0; r < 15; r++) begin
        if (ent_vld_d[i] && !ent_kill_d[i] && (ent_wa_d[i] == 4'(r))) begin
          pend_d[r] = 1'b1;
        end
      end
    end
  end

  // Destination routing: R15 goes to the PC, everything else to the register file.
  always_comb begin
    we3_d   = 1'b0;
    wa3_d   = wa3_q;
    wd3_d   = wd3_q;
    pc_we_d = 1'b0;
    pc_wd_d = pc_wd_q;
    if (iss_en) begin
      if (iss_wa == 4'd15) begin
        pc_we_d = 1'b1;
        pc_wd_d = iss_wd;
      end else begin
        we3_d = 1'b1;
        wa3_d = iss_wa;
        wd3_d = iss_wd;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_wa_q[i] <= '0;
        ent_wd_q[i] <= '0;
      end
      ent_vld_q  <= '0;
      ent_kill_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      we3_q      <= 1'b0;
      wa3_q      <= '0;
      wd3_q      <= '0;
      pc_we_q    <= 1'b0;
      pc_wd_q    <= '0;
    end else begin
      ent_wa_q   <= ent_wa_d;
      ent_wd_q   <= ent_wd_d;
      ent_vld_q  <= ent_vld_d;
      ent_kill_q <= ent_kill_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      we3_q      <= we3_d;
      wa3_q      <= wa3_d;
      wd3_q      <= wd3_d;
      pc_we_q    <= pc_we_d;
      pc_wd_q    <= pc_wd_d;
    end
  end

`ifdef RF_WRITE_PORT_CTRL_STATS_EN
  logic [15:0] kill_cnt_q, kill_cnt_d;
  logic [15:0] stall_cyc_q, stall_cyc_d;
  logic [5:0]  n_kill;
  logic [16:0] kill_sum;

  assign kill_cnt  = kill_cnt_q;
  assign stall_cyc = stall_cyc_q;

  // Saturating statistics: kills per cycle may be several, stalls at most one.
  always_comb begin
    n_kill = (enq && enq_kill) ? 6'd1 : 6'd0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      n_kill = n_kill + 6'(kill_hit[i]);
    end
    kill_sum   = 17'(kill_cnt_q) + 17'(n_kill);
    kill_cnt_d = kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
    stall_cyc_d = stall_cyc_q;
    if (ld_valid && !ld_ready && (stall_cyc_q != 16'hFFFF)) begin
      stall_cyc_d = stall_cyc_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kill_cnt_q  <= '0;
      stall_cyc_q <= '0;
    end else begin
      kill_cnt_q  <= kill_cnt_d;
      stall_cyc_q <= stall_cyc_d;
    end
  end
`endif

endmodule

// File: tb/tb_rf_write_port_ctrl.sv
// Self-checking bench for rf_write_port_ctrl: directed vector table, reset
// sequence, then randomized traffic against a queue-based reference model.
module tb_rf_write_port_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_we;
  logic [3:0]    alu_wa;
  logic [DW-1:0] alu_wd;
  logic          ld_valid;
  logic          ld_ready;
  logic [3:0]    ld_wa;
  logic [DW-1:0] ld_wd;
  logic          we3;
  logic [3:0]    wa3;
  logic [DW-1:0] wd3;
  logic          pc_we;
  logic [DW-1:0] pc_wd;
  logic [14:0]   pend_mask;
  logic [2:0]    fifo_count;

  int n_vec  = 0;
  int n_fail = 0;

  rf_write_port_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_we     (alu_we),
    .alu_wa     (alu_wa),
    .alu_wd     (alu_wd),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_wa      (ld_wa),
    .ld_wd      (ld_wd),
    .we3        (we3),
    .wa3        (wa3),
    .wd3        (wd3),
    .pc_we      (pc_we),
    .pc_wd      (pc_wd),
    .pend_mask  (pend_mask),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          aw;
    logic [3:0]  awa;
    logic [31:0] awd;
    bit          lv;
    logic [3:0]  lwa;
    logic [31:0] lwd;
    bit          e_rdy;
    bit          e_we3;
    logic [3:0]  e_wa3;
    logic [31:0] e_wd3;
    bit          e_pcwe;
    logic [31:0] e_pcwd;
    logic [2:0]  e_cnt;
    logic [14:0] e_pend;
  } vec_t;

  typedef struct {
    logic [3:0]  wa;
    logic [31:0] wd;
    bit          killed;
  } ment_t;

  vec_t  tv[$];
  ment_t mq[$];

  // Model expectations for the cycle after the current inputs
  bit          m_we3;
  logic [3:0]  m_wa3;
  logic [31:0] m_wd3;
  bit          m_pcwe;
  logic [31:0] m_pcwd;
  logic [2:0]  m_cnt;
  logic [14:0] m_pend;

  function automatic vec_t mk(bit aw, logic [3:0] awa, logic [31:0] awd,
                              bit lv, logic [3:0] lwa, logic [31:0] lwd,
                              bit rdy, bit ewe, logic [3:0] ewa, logic [31:0] ewd,
                              bit epc, logic [31:0] epd, logic [2:0] ecnt, logic [14:0] epend);
    vec_t v;
    v.aw = aw; v.awa = awa; v.awd = awd; v.lv = lv; v.lwa = lwa; v.lwd = lwd;
    v.e_rdy = rdy; v.e_we3 = ewe; v.e_wa3 = ewa; v.e_wd3 = ewd;
    v.e_pcwe = epc; v.e_pcwd = epd; v.e_cnt = ecnt; v.e_pend = epend;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit aw, input logic [3:0] awa, input logic [31:0] awd,
                       input bit lv, input logic [3:0] lwa, input logic [31:0] lwd);
    alu_we = aw; alu_wa = awa; alu_wd = awd;
    ld_valid = lv; ld_wa = lwa; ld_wd = lwd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: apply one cycle of the selection rules to the load queue.
  task automatic model_step(input bit aw, input logic [3:0] awa, input logic [31:0] awd,
                            input bit lv, input logic [3:0] lwa, input logic [31:0] lwd);
    bit          acc;
    bit          iss;
    logic [3:0]  iwa;
    logic [31:0] iwd;
    ment_t       h;
    ment_t       e;
    acc = lv && (mq.size() < DEPTH);
    iss = 1'b0;
    iwa = '0;
    iwd = '0;
    e.wa = lwa; e.wd = lwd; e.killed = 1'b0;
    if (aw) begin
      foreach (mq[i]) if (mq[i].wa == awa) mq[i].killed = 1'b1;
      iss = 1'b1; iwa = awa; iwd = awd;
      if (acc) begin
        e.killed = (lwa == awa);
        mq.push_back(e);
      end
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      if (!h.killed) begin
        iss = 1'b1; iwa = h.wa; iwd = h.wd;
      end
      if (acc) mq.push_back(e);
    end else if (acc) begin
      iss = 1'b1; iwa = lwa; iwd = lwd;
    end
    m_we3  = iss && (iwa != 4'd15);
    m_pcwe = iss && (iwa == 4'd15);
    m_wa3  = iwa;
    m_wd3  = iwd;
    m_pcwd = iwd;
    m_cnt  = 3'(mq.size());
    m_pend = '0;
    foreach (mq[i]) if (!mq[i].killed && mq[i].wa != 4'd15) m_pend[mq[i].wa] = 1'b1;
  endtask

  initial begin
    bit          hold;
    bit          aw, lv, rdy;
    logic [3:0]  awa, lwa;
    logic [31:0] awd, lwd;
    int          alu_pct;

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #10;
    chk("rst_we3", 32'(we3), 0);
    chk("rst_pc_we", 32'(pc_we), 0);
    chk("rst_wa3", 32'(wa3), 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_pc_wd", pc_wd, 0);
    chk("rst_cnt", 32'(fifo_count), 0);
    chk("rst_pend", 32'(pend_mask), 0);
    chk("rst_ready", 32'(ld_ready), 1);
    reset = 1'b0;

    // Directed table: basic ALU, bypass, fill/drain, WAW kills, R15 routing
    tv.push_back(mk(1, 3, 'hAA,  0, 0, 0,      1, 1, 3, 'hAA,  0, 0, 0, 'h0000));
    tv.push_back(mk(0, 0, 0,     0, 0, 0,      1, 0, 0, 0,     0, 0, 0, 'h0000));
    tv.push_back(mk(0, 0, 0,     1, 5, 'h1234, 1, 1, 5, 'h1234, 0, 0, 0, 'h0000));
    tv.push_back(mk(0, 0, 0,     0, 0, 0,      1, 0, 0, 0,     0, 0, 0, 'h0000));
    tv.push_back(mk(1, 0, 'h100, 1, 7, 'h707,  1, 1, 0, 'h100, 0, 0, 1, 'h0080));
    tv.push_back(mk(1, 1, 'h101, 1, 8, 'h808,  1, 1, 1, 'h101, 0, 0, 2, 'h0180));
    tv.push_back(mk(1, 2, 'h102, 1, 9, 'h909,  1, 1, 2, 'h102, 0, 0, 3, 'h0380));
    tv.push_back(mk(1, 3, 'h103, 1, 10, 'hA0A, 1, 1, 3, 'h103, 0, 0, 4, 'h0780));
    tv.push_back(mk(1, 4, 'h104, 1, 11, 'hB0B, 0, 1, 4, 'h104, 0, 0, 4, 'h0780));
    tv.push_back(mk(1, 5, 'h105, 1, 11, 'hB0B, 0, 1, 5, 'h105, 0, 0, 4, 'h0780));
    tv.push_back(mk(0, 0, 0,     1, 11, 'hB0B, 0, 1, 7, 'h707, 0, 0, 3, 'h0700));
    tv.push_back(mk(0, 0, 0,     1, 11, 'hB0B, 1, 1, 8, 'h808, 0, 0, 3, 'h0E00));
    tv.push_back(mk(0, 0, 0,     0, 0, 0,      1, 1, 9, 'h909, 0, 0, 2, 'h0C00));
    tv.push_back(mk(0, 0, 0,     0, 0, 0,      1, 1, 10, 'hA0A, 0, 0, 1, 'h0800));
    tv.push_back(mk(0, 0, 0,     0, 0, 0,      1, 1, 11, 'hB0B, 0, 0, 0, 'h0000));
    tv.push_back(mk(0, 0, 0,     0, 0, 0,      1, 0, 0, 0,     0, 0, 0, 'h0000));
    tv.push_back(mk(1, 1, 'h55,  1, 2, 'h11,   1, 1, 1, 'h55,  0, 0, 1, 'h0004));
    tv.push_back(mk(1, 2, 'h22,  0, 0, 0,      1, 1, 2, 'h22,  0, 0, 1, 'h0000));
    tv.push_back(mk(0, 0, 0,     0, 0, 0,      1, 0, 0, 0,     0, 0, 0, 'h0000));
    tv.push_back(mk(1, 6, 'h66,  1, 6, 'h77,   1, 1, 6, 'h66,  0, 0, 1, 'h0000));
    tv.push_back(mk(0, 0, 0,     0, 0, 0,      1, 0, 0, 0,     0, 0, 0, 'h0000));
    tv.push_back(mk(0, 0, 0,     1, 15, 'h100, 1, 0, 0, 0,     1, 'h100, 0, 'h0000));
    tv.push_back(mk(0, 0, 0,     0, 0, 0,      1, 0, 0, 0,     0, 0, 0, 'h0000));
    tv.push_back(mk(1, 15, 'h200, 0, 0, 0,     1, 0, 0, 0,     1, 'h200, 0, 'h0000));
    tv.push_back(mk(0, 0, 0,     0, 0, 0,      1, 0, 0, 0,     0, 0, 0, 'h0000));
    tv.push_back(mk(1, 0, 'h1,   1, 15, 'h300, 1, 1, 0, 'h1,   0, 0, 1, 'h0000));
    tv.push_back(mk(0, 0, 0,     0, 0, 0,      1, 0, 0, 0,     1, 'h300, 0, 'h0000));
    tv.push_back(mk(0, 0, 0,     0, 0, 0,      1, 0, 0, 0,     0, 0, 0, 'h0000));

    foreach (tv[k]) begin
      drive(tv[k].aw, tv[k].awa, tv[k].awd, tv[k].lv, tv[k].lwa, tv[k].lwd);
      chk($sformatf("tv%0d_ready", k), 32'(ld_ready), 32'(tv[k].e_rdy));
      tick();
      chk($sformatf("tv%0d_we3", k), 32'(we3), 32'(tv[k].e_we3));
      if (tv[k].e_we3) begin
        chk($sformatf("tv%0d_wa3", k), 32'(wa3), 32'(tv[k].e_wa3));
        chk($sformatf("tv%0d_wd3", k), wd3, tv[k].e_wd3);
      end
      chk($sformatf("tv%0d_pc_we", k), 32'(pc_we), 32'(tv[k].e_pcwe));
      if (tv[k].e_pcwe) chk($sformatf("tv%0d_pc_wd", k), pc_wd, tv[k].e_pcwd);
      chk($sformatf("tv%0d_cnt", k), 32'(fifo_count), 32'(tv[k].e_cnt));
      chk($sformatf("tv%0d_pend", k), 32'(pend_mask), 32'(tv[k].e_pend));
    end

    // Mid-drain reset: three loads queued, one popped, then async reset
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'(i), 32'(i), 1, 4'(i + 3), 32'h50 + 32'(i));
      tick();
    end
    chk("mr_cnt_full3", 32'(fifo_count), 3);
    chk("mr_pend3", 32'(pend_mask), 32'h0038);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("mr_drain_wa3", 32'(wa3), 3);
    reset = 1'b1;
    #1;
    chk("mr_cnt", 32'(fifo_count), 0);
    chk("mr_pend", 32'(pend_mask), 0);
    chk("mr_ready", 32'(ld_ready), 1);
    chk("mr_we3", 32'(we3), 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_post_we3", 32'(we3), 0);
      chk("mr_post_pc_we", 32'(pc_we), 0);
      chk("mr_post_cnt", 32'(fifo_count), 0);
    end

    // Randomized traffic against the queue model
    mq.delete();
    hold = 1'b0;
    lv = 1'b0; lwa = '0; lwd = '0;
    for (int c = 0; c < 600; c++) begin
      alu_pct = (c < 300) ? 7 : 3;
      aw  = ($urandom_range(0, 9) < alu_pct);
      awa = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
      awd = $urandom;
      if (!hold) begin
        lv  = ($urandom_range(0, 9) < 6);
        lwa = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
        lwd = $urandom;
      end
      drive(aw, awa, awd, lv, lwa, lwd);
      rdy = (mq.size() < DEPTH);
      chk("rnd_ready", 32'(ld_ready), 32'(rdy));
      model_step(aw, awa, awd, lv, lwa, lwd);
      hold = lv && !rdy;
      tick();
      chk("rnd_we3", 32'(we3), 32'(m_we3));
      if (m_we3) begin
        chk("rnd_wa3", 32'(wa3), 32'(m_wa3));
        chk("rnd_wd3", wd3, m_wd3);
      end
      chk("rnd_pc_we", 32'(pc_we), 32'(m_pcwe));
      if (m_pcwe) chk("rnd_pc_wd", pc_wd, m_pcwd);
      chk("rnd_cnt", 32'(fifo_count), 32'(m_cnt));
      chk("rnd_pend", 32'(pend_mask), 32'(m_pend));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_write_port_ctrl.md
Name: rf_write_port_ctrl

Overview:
- Writer-side controller for the CPU register file's single write port (we3/wa3/wd3).
- Merges two write sources into one registered write per cycle: single-cycle ALU results and multi-cycle load returns. Load returns use a valid/ready handshake and are buffered in a small FIFO.
- Diverts writes addressed to R15 to the PC path, since the register file stores only R0-R14.
- Exports a pending-write mask so decode can stall reads of registers with queued writes.

Parameters:
- DEPTH, 4, load-return FIFO entries; power of two, 2..16.
- DW, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- alu_we  in  1  ALU result write request; always accepted, no backpressure.
- alu_wa  in  4  ALU destination register.
- alu_wd  in  DW  ALU result.
- ld_valid  in  1  load return valid.
- ld_ready  out  1  FIFO can accept a load return.
- ld_wa  in  4  load destination register.
- ld_wd  in  DW  load data.
- we3  out  1  register-file write enable.
- wa3  out  4  register-file write address, 0..14 only.
- wd3  out  DW  register-file write data.
- pc_we  out  1  PC write enable (destination was R15).
- pc_wd  out  DW  PC write data.
- pend_mask  out  15  bit i set = live queued load write to Ri.
- fifo_count  out  $clog2(DEPTH)+1  number of FIFO entries, live or killed.

Behaviour:
- Reset (async assert) clears to 0: we3, wa3, wd3, pc_we, pc_wd, pend_mask, fifo_count, and all FIFO entry valid/kill bits. ld_ready is 1 after reset.
- Load handshake: a transfer occurs when ld_valid && ld_ready. ld_ready = (fifo_count < DEPTH) and is combinational from registered state. The source holds ld_wa/ld_wd stable while ld_valid && !ld_ready.
- Output timing: outputs are registered, with exactly one cycle from selection to we3/pc_we. At most one of we3 and pc_we is high per cycle. Each write pulse lasts one cycle.
- Per-cycle selection, in priority order:
  1. alu_we = 1: the ALU write is issued. An accepted load that cycle is enqueued.
  2. Otherwise the FIFO is non-empty: the head is popped. If the head is live it is issued; a killed head is popped silently. An accepted load that cycle is enqueued.
  3. Otherwise the FIFO is empty and a load is accepted: the load bypasses the FIFO and is issued directly, with no enqueue.
- Destination routing: if the issued destination is 15, drive pc_we=1 and pc_wd=data, with we3=0. Otherwise drive we3=1, wa3=dest and wd3=data.
- Ordering / WAW: when alu_we=1 with alu_wa=k, every queued live entry with wa=k is marked killed in the same cycle, so the younger ALU value wins. A load accepted in the same cycle with ld_wa=k is older-in-program-order by contract and is also killed on enqueue.
- pend_mask: the OR over live entries, excluding wa=15. Updated registered, so it is valid the cycle after enqueue, kill or pop.
- Full FIFO: ld_ready=0 and ALU writes continue. Killed entries still occupy slots until popped.
- Simultaneous pop and push when full: not allowed. ld_ready is computed from the pre-pop count, so there is no same-cycle slot reuse.
- Pointers: wrap modulo DEPTH. fifo_count never exceeds DEPTH and never underflows.
- Mid-operation reset: the FIFO contents are discarded and no write pulse is emitted on the edge after reset deasserts.

Optional Feature:
- Macro: RF_WRITE_PORT_CTRL_STATS_EN.
- When defined, the block adds output port kill_cnt (16 bits) and output port stall_cyc (16 bits).
  - kill_cnt counts entries killed by the WAW rule.
  - stall_cyc counts cycles with ld_valid && !ld_ready.
  - Both counters saturate at 0xFFFF and reset to 0.
- When undefined, neither port nor the counter logic exists. All other behaviour is identical.

Test Plan:
- Reset, then alu_we=1, alu_wa=3, alu_wd=0x0000_00AA for one cycle -> next cycle we3=1, wa3=3, wd3=0xAA; the following cycle we3=0.
- FIFO empty, alu_we=0, load ld_wa=5, ld_wd=0x1234 -> bypass: next cycle we3=1, wa3=5, wd3=0x1234; fifo_count remains 0.
- Hold alu_we=1 for 6 cycles with distinct addresses 0..5 while offering loads to R7..R10 (DEPTH=4) -> 4 loads accepted and the 5th sees ld_ready=0; pend_mask=0x0780. After ALU stops, 4 consecutive writes to R7, R8, R9, R10 in order.
- Queue a load to R2 (0x11) behind ALU activity, then alu_we=1, alu_wa=2, alu_wd=0x22 -> pend_mask[2] clears. The R2 value written last is 0x22, and no 0x11 write ever appears on we3.
- Load to R15 with data 0x0000_0100, FIFO empty -> next cycle pc_we=1, pc_wd=0x100, we3=0. ALU write to R15 behaves the same.
- Three loads queued, then assert reset for one cycle mid-drain -> fifo_count=0, pend_mask=0 and ld_ready=1 immediately. No we3 pulse follows until new stimulus.
